// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the VGA timing generator to the pixel drawers and the video DAC.
interface vga_timing_gen_if;
  logic       pixel_tick;
  logic       vga_clk;
  logic       hsync;
  logic       vsync;
  logic       display_enabled;
  logic [9:0] x;
  logic [8:0] y;
  logic       line_start;
  logic       frame_start;
  logic       vga_blank_n;
  logic       vga_sync_n;

  modport master (
    output pixel_tick, vga_clk, hsync, vsync, display_enabled, x, y,
           line_start, frame_start, vga_blank_n, vga_sync_n
  );

  modport slave (
    input  pixel_tick, vga_clk, hsync, vsync, display_enabled, x, y,
           line_start, frame_start, vga_blank_n, vga_sync_n
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel tick divider, h/v counters, active-low syncs, display window, coordinates.
// Outputs are registered one clk after each tick edge and hold for the pixel period; free-running, no backpressure.
module vga_timing_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [9:0]       h_cnt, v_cnt, h_nxt, v_nxt;
  logic             h_wrap, v_wrap;

  logic       tick_q, vclk_q, hsync_q, vsync_q, de_q, line_start_q, frame_start_q;
  logic [9:0] x_q;
  logic [8:0] y_q;

  always_comb begin
    div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
    h_wrap  = (h_cnt == H_LAST);
    v_wrap  = (v_cnt == V_LAST);
    h_nxt   = h_wrap ? 10'd0 : h_cnt + 10'd1;
    v_nxt   = v_cnt;
    if (h_wrap) begin
      v_nxt = v_wrap ? 10'd0 : v_cnt + 10'd1;
    end
  end

  // Counters park at the last pixel of the frame so the first tick lands on (0,0) with frame_start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt       <= '0;
      h_cnt         <= H_LAST;
      v_cnt         <= V_LAST;
      tick_q        <= 1'b0;
      vclk_q        <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt       <= div_nxt;
      tick_q        <= (div_cnt == DIV_LAST);
      vclk_q        <= (div_nxt >= DIV_HALF);
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      if (tick_q) begin
        // Decode from the next counter values so outputs and counters never disagree.
        h_cnt         <= h_nxt;
        v_cnt         <= v_nxt;
        hsync_q       <= !((h_nxt >= HS_FIRST) && (h_nxt <= HS_LAST));
        vsync_q       <= !((v_nxt >= VS_FIRST) && (v_nxt <= VS_LAST));
        de_q          <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
        x_q           <= (h_nxt < H_VIS) ? h_nxt : 10'd0;
        y_q           <= (v_nxt < V_VIS) ? v_nxt[8:0] : 9'd0;
        line_start_q  <= h_wrap;
        frame_start_q <= h_wrap && v_wrap;
      end
    end
  end

  assign vga.pixel_tick      = tick_q;
  assign vga.vga_clk         = vclk_q;
  assign vga.hsync           = hsync_q;
  assign vga.vsync           = vsync_q;
  assign vga.display_enabled = de_q;
  assign vga.x               = x_q;
  assign vga.y               = y_q;
  assign vga.line_start      = line_start_q;
  assign vga.frame_start     = frame_start_q;
  assign vga.vga_blank_n     = de_q;
  assign vga.vga_sync_n      = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full 640x480 geometry at CLK_DIV 2 and 4, plus a shrunken geometry for frame-level timing.
module tb_vga_timing_gen;

  typedef struct packed {
    logic       tick;
    logic       vclk;
    logic       hs;
    logic       vs;
    logic       de;
    logic [9:0] x;
    logic [8:0] y;
    logic       ls;
    logic       fs;
    logic       bn;
    logic       sn;
  } vid_t;

  typedef struct packed {
    int cd; int hv; int hf; int hsy; int hb; int vv; int vf; int vsy; int vb;
  } geo_t;

  localparam vid_t RST_V = '{tick: 1'b0, vclk: 1'b0, hs: 1'b1, vs: 1'b1, de: 1'b0,
                             x: 10'd0, y: 9'd0, ls: 1'b0, fs: 1'b0, bn: 1'b0, sn: 1'b0};

  logic       clk;
  logic [2:0] rst_n;
  vid_t       obs [3];
  vid_t       exp_q [$];
  int         ecnt [3];
  int         vectors;
  int         miscompares;

  vga_timing_gen_if u_if0 ();
  vga_timing_gen_if u_if1 ();
  vga_timing_gen_if u_if2 ();

  vga_timing_gen #(.CLK_DIV(2)) u_full (.clk(clk), .rst_n(rst_n[0]), .vga(u_if0));

  vga_timing_gen #(
    .CLK_DIV(2), .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
    .V_VISIBLE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) u_small (.clk(clk), .rst_n(rst_n[1]), .vga(u_if1));

  vga_timing_gen #(.CLK_DIV(4)) u_div4 (.clk(clk), .rst_n(rst_n[2]), .vga(u_if2));

  assign obs[0] = {u_if0.pixel_tick, u_if0.vga_clk, u_if0.hsync, u_if0.vsync, u_if0.display_enabled,
                   u_if0.x, u_if0.y, u_if0.line_start, u_if0.frame_start, u_if0.vga_blank_n, u_if0.vga_sync_n};
  assign obs[1] = {u_if1.pixel_tick, u_if1.vga_clk, u_if1.hsync, u_if1.vsync, u_if1.display_enabled,
                   u_if1.x, u_if1.y, u_if1.line_start, u_if1.frame_start, u_if1.vga_blank_n, u_if1.vga_sync_n};
  assign obs[2] = {u_if2.pixel_tick, u_if2.vga_clk, u_if2.hsync, u_if2.vsync, u_if2.display_enabled,
                   u_if2.x, u_if2.y, u_if2.line_start, u_if2.frame_start, u_if2.vga_blank_n, u_if2.vga_sync_n};

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  function automatic geo_t geo(input int s);
    geo_t g;
    case (s)
      1:       g = '{cd: 2, hv: 16, hf: 4, hsy: 6, hb: 6, vv: 8, vf: 2, vsy: 2, vb: 3};
      2:       g = '{cd: 4, hv: 640, hf: 16, hsy: 96, hb: 48, vv: 480, vf: 10, vsy: 2, vb: 33};
      default: g = '{cd: 2, hv: 640, hf: 16, hsy: 96, hb: 48, vv: 480, vf: 10, vsy: 2, vb: 33};
    endcase
    return g;
  endfunction

  // Expected outputs after the e-th clk edge since reset release, derived from a flat pixel index.
  function automatic vid_t model(input int s, input int e);
    geo_t g;
    vid_t r;
    int   n, h, v, ht, vt;
    g  = geo(s);
    ht = g.hv + g.hf + g.hsy + g.hb;
    vt = g.vv + g.vf + g.vsy + g.vb;
    r  = RST_V;
    if (e > 0) begin
      r.tick = (e >= g.cd) && (e % g.cd == 0);
      r.vclk = (e % g.cd) >= (g.cd / 2);
    end
    if (e > g.cd) begin
      n    = (e - 1) / g.cd - 1;
      h    = n % ht;
      v    = (n / ht) % vt;
      r.hs = !(h >= g.hv + g.hf && h < g.hv + g.hf + g.hsy);
      r.vs = !(v >= g.vv + g.vf && v < g.vv + g.vf + g.vsy);
      r.de = (h < g.hv) && (v < g.vv);
      r.bn = r.de;
      r.x  = (h < g.hv) ? 10'(h) : 10'd0;
      r.y  = (v < g.vv) ? 9'(v) : 9'd0;
      r.ls = ((e - 1) % g.cd == 0) && (h == 0);
      r.fs = ((e - 1) % g.cd == 0) && (h == 0) && (v == 0);
    end
    return r;
  endfunction

  // Scoreboard: predictions pushed at each edge from the reset stimulus, popped once outputs settle.
  initial begin
    vid_t ev;
    for (int s = 0; s < 3; s++) ecnt[s] = 0;
    forever begin
      @(posedge clk);
      for (int s = 0; s < 3; s++) begin
        ecnt[s] = rst_n[s] ? ecnt[s] + 1 : 0;
        exp_q.push_back(model(s, ecnt[s]));
      end
      #1;
      for (int s = 0; s < 3; s++) begin
        ev = exp_q.pop_front();
        vectors++;
        if (obs[s] !== ev) begin
          miscompares++;
          $display("FAIL scoreboard dut%0d edge %0d: got %h want %h", s, ecnt[s], obs[s], ev);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 3'b000;
    repeat (3) @(posedge clk);
    #2;
    for (int s = 0; s < 3; s++) begin
      vectors++;
      if (obs[s] !== RST_V) begin
        miscompares++;
        $display("FAIL reset_values dut%0d: got %h want %h", s, obs[s], RST_V);
      end
    end
  endtask

  task automatic test_first_tick();
    @(negedge clk);
    rst_n = 3'b111;
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk);
      #2;
      vectors++;
      if (obs[0].tick !== (e % 2 == 0)) begin
        miscompares++;
        $display("FAIL first_tick_div2 edge %0d: got %b want %b", e, obs[0].tick, (e % 2 == 0));
      end
      vectors++;
      if (obs[2].tick !== (e == 4)) begin
        miscompares++;
        $display("FAIL first_tick_div4 edge %0d: got %b want %b", e, obs[2].tick, (e == 4));
      end
      if (e == 3) begin
        vectors++;
        if ({obs[0].x, obs[0].y, obs[0].de, obs[0].fs, obs[0].ls} !== {10'd0, 9'd0, 3'b111}) begin
          miscompares++;
          $display("FAIL first_pixel_div2: x=%0d y=%0d de=%b fs=%b ls=%b want 0 0 1 1 1",
                   obs[0].x, obs[0].y, obs[0].de, obs[0].fs, obs[0].ls);
        end
      end
      if (e == 5) begin
        vectors++;
        if ({obs[2].x, obs[2].de, obs[2].fs} !== {10'd0, 2'b11}) begin
          miscompares++;
          $display("FAIL first_pixel_div4: x=%0d de=%b fs=%b want 0 1 1", obs[2].x, obs[2].de, obs[2].fs);
        end
      end
    end
  endtask

  task automatic test_divider();
    int   highs, changes, tcount, gap_bad, last;
    logic prev;
    @(posedge clk);
    #2;
    prev    = obs[0].vclk;
    highs   = 0;
    changes = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #2;
      if (obs[0].vclk) highs++;
      if (obs[0].vclk !== prev) changes++;
      prev = obs[0].vclk;
    end
    vectors++;
    if (highs != 4 || changes != 8) begin
      miscompares++;
      $display("FAIL vga_clk_div2: highs=%0d toggles=%0d want 4 8", highs, changes);
    end
    tcount = 0; gap_bad = 0; last = -1; highs = 0;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk);
      #2;
      if (obs[2].vclk) highs++;
      if (obs[2].tick) begin
        if (last >= 0 && i - last != 4) gap_bad++;
        last = i;
        tcount++;
      end
    end
    vectors++;
    if (tcount != 8 || gap_bad != 0) begin
      miscompares++;
      $display("FAIL tick_period_div4: ticks=%0d bad_gaps=%0d want 8 0", tcount, gap_bad);
    end
    vectors++;
    if (highs != 16) begin
      miscompares++;
      $display("FAIL vga_clk_div4_duty: highs=%0d want 16", highs);
    end
  endtask

  task automatic test_line(input int s);
    geo_t g;
    int   ht, cycles, ticks, de_ticks, hs_ticks, hs_first, x_bad;
    bit   ok;
    g  = geo(s);
    ht = g.hv + g.hf + g.hsy + g.hb;
    ok = 0;
    for (int i = 0; i < ht * g.cd + 8 && !ok; i++) begin
      @(posedge clk);
      #2;
      ok = obs[s].ls;
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL line_start_seen dut%0d: none within budget", s);
    end else begin
      cycles = 0; ticks = 0; de_ticks = 0; hs_ticks = 0; hs_first = -1; x_bad = 0; ok = 0;
      while (!ok && cycles < 2 * ht * g.cd) begin
        @(posedge clk);
        #2;
        cycles++;
        if (obs[s].ls) ok = 1;
        else if (obs[s].tick) begin
          if (obs[s].de) de_ticks++;
          if (obs[s].x !== ((ticks < g.hv) ? 10'(ticks) : 10'd0)) x_bad++;
          if (!obs[s].hs) begin
            if (hs_first < 0) hs_first = ticks;
            hs_ticks++;
          end
          ticks++;
        end
      end
      vectors++;
      if (ticks != ht || cycles != ht * g.cd) begin
        miscompares++;
        $display("FAIL line_length dut%0d: ticks=%0d clks=%0d want %0d %0d", s, ticks, cycles, ht, ht * g.cd);
      end
      vectors++;
      if (de_ticks != g.hv) begin
        miscompares++;
        $display("FAIL line_display_enabled dut%0d: got %0d want %0d", s, de_ticks, g.hv);
      end
      vectors++;
      if (hs_ticks != g.hsy || hs_first != g.hv + g.hf) begin
        miscompares++;
        $display("FAIL hsync_window dut%0d: low %0d from %0d want %0d from %0d",
                 s, hs_ticks, hs_first, g.hsy, g.hv + g.hf);
      end
      vectors++;
      if (x_bad != 0) begin
        miscompares++;
        $display("FAIL x_sequence dut%0d: %0d wrong pixels want 0", s, x_bad);
      end
    end
  endtask

  task automatic test_frame(input int s);
    geo_t g;
    int   ht, vt, budget, cycles, line, ls_cnt, de_ticks, blank_de, vs_ticks, vs_bad, y_bad, ymax;
    bit   ok;
    g      = geo(s);
    ht     = g.hv + g.hf + g.hsy + g.hb;
    vt     = g.vv + g.vf + g.vsy + g.vb;
    budget = 2 * ht * vt * g.cd + 8;
    ok     = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk);
      #2;
      ok = obs[s].fs;
    end
    vectors++;
    if (!ok || obs[s].ls !== 1'b1) begin
      miscompares++;
      $display("FAIL frame_start_with_line_start dut%0d: seen=%0b ls=%b want 1 1", s, ok, obs[s].ls);
    end else begin
      cycles = 0; line = 0; ls_cnt = 1; de_ticks = 0; blank_de = 0;
      vs_ticks = 0; vs_bad = 0; y_bad = 0; ymax = 0; ok = 0;
      while (!ok && cycles < budget) begin
        @(posedge clk);
        #2;
        cycles++;
        if (obs[s].fs) ok = 1;
        else begin
          if (obs[s].ls) begin
            ls_cnt++;
            line++;
          end
          if (obs[s].tick) begin
            if (obs[s].de) begin
              de_ticks++;
              if (line >= g.vv) blank_de++;
              if (obs[s].y !== 9'(line)) y_bad++;
              if (int'(obs[s].y) > ymax) ymax = int'(obs[s].y);
            end
            if (!obs[s].vs) vs_ticks++;
            if (obs[s].vs !== !(line >= g.vv + g.vf && line < g.vv + g.vf + g.vsy)) vs_bad++;
          end
        end
      end
      vectors++;
      if (!ok || ls_cnt != vt) begin
        miscompares++;
        $display("FAIL frame_lines dut%0d: %0d line_starts want %0d", s, ls_cnt, vt);
      end
      vectors++;
      if (vs_ticks != g.vsy * ht || vs_bad != 0) begin
        miscompares++;
        $display("FAIL vsync_window dut%0d: low ticks %0d bad %0d want %0d 0", s, vs_ticks, vs_bad, g.vsy * ht);
      end
      vectors++;
      if (de_ticks != g.vv * g.hv || blank_de != 0) begin
        miscompares++;
        $display("FAIL frame_display_enabled dut%0d: %0d ticks, %0d in vblank, want %0d 0",
                 s, de_ticks, blank_de, g.vv * g.hv);
      end
      vectors++;
      if (y_bad != 0 || ymax != g.vv - 1) begin
        miscompares++;
        $display("FAIL y_sequence dut%0d: bad %0d max %0d want 0 %0d", s, y_bad, ymax, g.vv - 1);
      end
    end
  endtask

  task automatic test_mid_frame_reset();
    int lines, first_fs;
    bit ok;
    ok = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(posedge clk);
      #2;
      ok = obs[1].fs;
    end
    lines = 0;
    for (int i = 0; i < 2000 && ok; i++) begin
      @(posedge clk);
      #2;
      if (obs[1].ls) lines++;
      if (lines >= 5 && obs[1].hs === 1'b0) break;
    end
    vectors++;
    if (!ok || lines < 5 || obs[1].hs !== 1'b0) begin
      miscompares++;
      $display("FAIL midframe_setup: fs=%0b lines=%0d hsync=%b want 1 5 0", ok, lines, obs[1].hs);
    end
    @(negedge clk);
    #3;
    rst_n[1] = 1'b0;
    #1;
    vectors++;
    if (obs[1] !== RST_V) begin
      miscompares++;
      $display("FAIL async_reset: got %h want %h", obs[1], RST_V);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n[1] = 1'b1;
    first_fs = -1;
    for (int e = 1; e <= 8 && first_fs < 0; e++) begin
      @(posedge clk);
      #2;
      if (obs[1].fs) first_fs = e;
    end
    vectors++;
    if (first_fs != 3 || obs[1].x !== 10'd0 || obs[1].y !== 9'd0) begin
      miscompares++;
      $display("FAIL restart_frame_start: edge %0d x=%0d y=%0d want 3 0 0", first_fs, obs[1].x, obs[1].y);
    end
    test_frame(1);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 3'b000;
    test_reset();
    test_first_tick();
    test_divider();
    test_line(0);
    test_line(2);
    test_frame(1);
    test_mid_frame_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
